// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared definitions for the multicycle MIPS control unit.
//   - state_e   : control FSM state encoding (also exported as current_state)
//   - OP_* / FN_*: opcode and R-type funct field values
//   - ALU_*     : 4-bit ALU_Ctl operation codes
//   - aluop_e   : internal ALU operation class passed to the ALU decoder
//   - imm_aluop / imm_sext: per-opcode decode for the immediate ALU group
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BR     = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JMP    = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [2:0] {
        AOP_ADD   = 3'd0,
        AOP_SUB   = 3'd1,
        AOP_FUNCT = 3'd2,
        AOP_AND   = 3'd3,
        AOP_OR    = 3'd4,
        AOP_SLT   = 3'd5
    } aluop_e;

    // ALU operation for the immediate group; anything else falls back to add.
    function automatic aluop_e imm_aluop(input logic [5:0] op);
        case (op)
            OP_SLTI: return AOP_SLT;
            OP_ANDI: return AOP_AND;
            OP_ORI:  return AOP_OR;
            default: return AOP_ADD;
        endcase
    endfunction

    // Arithmetic immediates are sign-extended, logical ones zero-extended.
    function automatic logic imm_sext(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_alu_dec.sv
// mips_alu_dec: combinational ALU decoder.
//   alu_op  in  3          internal ALU operation class (aluop_e)
//   funct   in  6          instruction[5:0], used when alu_op is AOP_FUNCT
//   alu_ctl out ALU_CTL_W  ALU operation code, zero-extended above bit 3
module mips_alu_dec
    import mips_mc_pkg::*;
#(
    parameter int ALU_CTL_W = 4
) (
    input  logic [2:0]           alu_op,
    input  logic [5:0]           funct,
    output logic [ALU_CTL_W-1:0] alu_ctl
);

    logic [3:0] ctl;

    always_comb begin
        ctl = ALU_ADD;
        case (aluop_e'(alu_op))
            AOP_ADD: ctl = ALU_ADD;
            AOP_SUB: ctl = ALU_SUB;
            AOP_AND: ctl = ALU_AND;
            AOP_OR:  ctl = ALU_OR;
            AOP_SLT: ctl = ALU_SLT;
            AOP_FUNCT: begin
                case (funct)
                    FN_ADD:  ctl = ALU_ADD;
                    FN_SUB:  ctl = ALU_SUB;
                    FN_AND:  ctl = ALU_AND;
                    FN_OR:   ctl = ALU_OR;
                    FN_NOR:  ctl = ALU_NOR;
                    FN_SLT:  ctl = ALU_SLT;
                    default: ctl = ALU_ADD;
                endcase
            end
            default: ctl = ALU_ADD;
        endcase
    end

    assign alu_ctl = ALU_CTL_W'(ctl);

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control unit (Moore FSM + ALU decoder).
// Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type,
// beq/bne, addi/andi/ori/slti and j; unknown opcodes go through TRAP.
// Ports:
//   clk, rst (synchronous, active-low)
//   Opcode, Funct       instruction fields from the IR
//   mem_ready           memory handshake (only honoured with MEM_WAIT_EN)
//   MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSrc   datapath mux selects
//   IRWrite, MemWrite, PCWrite, BEQ, BNE, RegWrite, ExtOp   enables
//   ALU_Ctl             ALU operation
//   instr_done          pulse in the last state of each instruction
//   illegal_op          pulse in TRAP
//   current_state       state encoding for debug
// Build option: define MEM_WAIT_EN to stall FETCH, MEMRD and MEMWR until
// mem_ready is high; otherwise those states take one cycle each.
module mips_mc_ctrl
    import mips_mc_pkg::*;
#(
    parameter int STATE_W   = 4,
    parameter int ALU_CTL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           Funct,
    input  logic                 mem_ready,
    output logic                 MemtoReg,
    output logic                 RegDst,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSrc,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 PCWrite,
    output logic                 BEQ,
    output logic                 BNE,
    output logic                 RegWrite,
    output logic                 ExtOp,
    output logic [ALU_CTL_W-1:0] ALU_Ctl,
    output logic                 instr_done,
    output logic                 illegal_op,
    output logic [STATE_W-1:0]   current_state
);

    state_e     state_q, state_d;
    aluop_e     alu_op;
    logic       mem_ok;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        BEQ        = 1'b0;
        BNE        = 1'b0;
        RegWrite   = 1'b0;
        ExtOp      = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        alu_op     = AOP_ADD;

        case (state_q)
            S_FETCH: begin
                // PC+4 and IR load only commit once the fetch has returned.
                IRWrite = mem_ok;
                PCWrite = mem_ok;
                ALUSrcB = 2'b01;
                state_d = mem_ok ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW:                       state_d = S_MEMADR;
                    OP_RTYPE:                           state_d = S_REX;
                    OP_BEQ, OP_BNE:                     state_d = S_BR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_IMMEX;
                    OP_J:                               state_d = S_JMP;
                    default:                            state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 1'b1;
                state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                state_d = mem_ok ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                // Write strobe stays up across wait cycles; done only on completion.
                MemWrite   = 1'b1;
                instr_done = mem_ok;
                state_d    = mem_ok ? S_FETCH : S_MEMWR;
            end
            S_REX: begin
                ALUSrcA = 1'b1;
                alu_op  = AOP_FUNCT;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BR: begin
                ALUSrcA    = 1'b1;
                alu_op     = AOP_SUB;
                PCSrc      = 2'b01;
                BEQ        = (Opcode == OP_BEQ);
                BNE        = (Opcode == OP_BNE);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_op  = imm_aluop(Opcode);
                ExtOp   = imm_sext(Opcode);
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                // ALU result is still being written back, so keep its controls.
                alu_op     = imm_aluop(Opcode);
                ExtOp      = imm_sext(Opcode);
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JMP: begin
                PCWrite    = 1'b1;
                PCSrc      = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // While reset is held the outputs look like FETCH regardless of the
        // registered state or a pending memory wait.
        if (!rst) begin
            MemtoReg   = 1'b0;
            RegDst     = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b01;
            PCSrc      = 2'b00;
            IRWrite    = 1'b1;
            MemWrite   = 1'b0;
            PCWrite    = 1'b1;
            BEQ        = 1'b0;
            BNE        = 1'b0;
            RegWrite   = 1'b0;
            ExtOp      = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
            alu_op     = AOP_ADD;
        end
    end

    mips_alu_dec #(.ALU_CTL_W(ALU_CTL_W)) u_alu_dec (
        .alu_op  (alu_op),
        .funct   (Funct),
        .alu_ctl (ALU_Ctl)
    );

    assign current_state = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: reset check, table of per-opcode
// cycle/pulse counts, per-cycle checks against a behavioural model, random
// instruction stream, mid-instruction reset and (with MEM_WAIT_EN) waits.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode, Funct;
    logic       mem_ready;
    logic       MemtoReg, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic       IRWrite, MemWrite, PCWrite, BEQ, BNE, RegWrite, ExtOp;
    logic [3:0] ALU_Ctl;
    logic       instr_done, illegal_op;
    logic [3:0] current_state;

    int checks = 0;
    int failures = 0;

    mips_mc_ctrl #(.STATE_W(4), .ALU_CTL_W(4)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct),
        .mem_ready(mem_ready), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .PCWrite(PCWrite),
        .BEQ(BEQ), .BNE(BNE), .RegWrite(RegWrite), .ExtOp(ExtOp),
        .ALU_Ctl(ALU_Ctl), .instr_done(instr_done), .illegal_op(illegal_op),
        .current_state(current_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       m2r, rdst, asa;
        logic [1:0] asb, pcs;
        logic       irw, mw, pcw, beq, bne, rw, ext;
        logic [3:0] alu;
        logic       done, ill;
    } ctl_t;

    // State sequence an instruction walks through, by instruction class.
    int path_q[$];
    function automatic void build_path(input logic [5:0] op);
        path_q = {};
        case (op)
            6'h23:                      path_q = {0, 1, 2, 3, 4};
            6'h2B:                      path_q = {0, 1, 2, 5};
            6'h00:                      path_q = {0, 1, 6, 7};
            6'h04, 6'h05:               path_q = {0, 1, 8};
            6'h08, 6'h0A, 6'h0C, 6'h0D: path_q = {0, 1, 9, 10};
            6'h02:                      path_q = {0, 1, 11};
            default:                    path_q = {0, 1, 12};
        endcase
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'h20: return 4'b0010;
            6'h22: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h27: return 4'b1100;
            6'h2A: return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic [3:0] imm_alu(input logic [5:0] op);
        case (op)
            6'h0A: return 4'b0111;
            6'h0C: return 4'b0000;
            6'h0D: return 4'b0001;
            default: return 4'b0010;
        endcase
    endfunction

    // Expected outputs in a given state; mr is the memory-ready seen by the DUT.
    function automatic ctl_t model(input int st, input logic [5:0] op,
                                   input logic [5:0] f, input logic mr);
        ctl_t c;
        c = '0;
        c.st = st[3:0];
        c.alu = 4'b0010;
        case (st)
            0:  begin c.irw = mr; c.pcw = mr; c.asb = 2'b01; end
            1:  c.asb = 2'b11;
            2:  begin c.asa = 1; c.asb = 2'b10; c.ext = 1; end
            4:  begin c.rw = 1; c.m2r = 1; c.done = 1; end
            5:  begin c.mw = 1; c.done = mr; end
            6:  begin c.asa = 1; c.alu = funct_alu(f); end
            7:  begin c.rw = 1; c.rdst = 1; c.done = 1; end
            8:  begin c.asa = 1; c.alu = 4'b0110; c.pcs = 2'b01;
                      c.beq = (op == 6'h04); c.bne = (op == 6'h05); c.done = 1; end
            9:  begin c.asa = 1; c.asb = 2'b10; c.alu = imm_alu(op);
                      c.ext = (op == 6'h08) || (op == 6'h0A); end
            10: begin c.rw = 1; c.done = 1; c.alu = imm_alu(op);
                      c.ext = (op == 6'h08) || (op == 6'h0A); end
            11: begin c.pcw = 1; c.pcs = 2'b10; c.done = 1; end
            12: c.ill = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t sample();
        ctl_t g;
        g.st = current_state; g.m2r = MemtoReg; g.rdst = RegDst; g.asa = ALUSrcA;
        g.asb = ALUSrcB; g.pcs = PCSrc; g.irw = IRWrite; g.mw = MemWrite;
        g.pcw = PCWrite; g.beq = BEQ; g.bne = BNE; g.rw = RegWrite; g.ext = ExtOp;
        g.alu = ALU_Ctl; g.done = instr_done; g.ill = illegal_op;
        return g;
    endfunction

    task automatic check(input string name, input ctl_t exp);
        ctl_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s op=%h fn=%h got=%h exp=%h", name, Opcode, Funct, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction (no memory waits) and checks every cycle.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] f);
        Opcode = op;
        Funct  = f;
        build_path(op);
        foreach (path_q[i]) begin
`ifdef MEM_WAIT_EN
            mem_ready = 1'b1;
`else
            mem_ready = 1'($urandom_range(0, 1));
`endif
            check(name, model(path_q[i], op, f, 1'b1));
            tick();
        end
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         cyc;
        int         done;
        int         ill;
    } vec_t;

    vec_t vecs[13];
    logic [5:0] legal_ops[10];
    logic [5:0] fns[7];

    initial begin
        vecs[0]  = '{6'h23, 6'h20, 5, 1, 0};
        vecs[1]  = '{6'h2B, 6'h20, 4, 1, 0};
        vecs[2]  = '{6'h00, 6'h22, 4, 1, 0};
        vecs[3]  = '{6'h00, 6'h3F, 4, 1, 0};
        vecs[4]  = '{6'h04, 6'h00, 3, 1, 0};
        vecs[5]  = '{6'h05, 6'h00, 3, 1, 0};
        vecs[6]  = '{6'h08, 6'h00, 4, 1, 0};
        vecs[7]  = '{6'h0A, 6'h00, 4, 1, 0};
        vecs[8]  = '{6'h0C, 6'h00, 4, 1, 0};
        vecs[9]  = '{6'h0D, 6'h00, 4, 1, 0};
        vecs[10] = '{6'h02, 6'h00, 3, 1, 0};
        vecs[11] = '{6'h3F, 6'h00, 3, 0, 1};
        vecs[12] = '{6'h01, 6'h00, 3, 0, 1};
        legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};

        // Reset: FETCH outputs even with memory not ready.
        rst = 1'b0; Opcode = 6'h23; Funct = 6'h20; mem_ready = 1'b0;
        tick();
        check("reset", model(0, 6'h23, 6'h20, 1'b1));
        tick();
        rst = 1'b1;

        // Test-plan instructions, per-cycle model checks.
        run_instr("lw",      6'h23, 6'h20);
        run_instr("rsub",    6'h00, 6'h22);
        run_instr("rbadfn",  6'h00, 6'h3F);
        run_instr("bne",     6'h05, 6'h00);
        run_instr("beq",     6'h04, 6'h00);
        run_instr("ori",     6'h0D, 6'h00);
        run_instr("addi",    6'h08, 6'h00);
        run_instr("illegal", 6'h3F, 6'h00);

        // Table: cycle count and pulse counts per instruction.
        foreach (vecs[k]) begin
            int n, nd, ni;
            n = 0; nd = 0; ni = 0;
            Opcode = vecs[k].op; Funct = vecs[k].fn;
`ifdef MEM_WAIT_EN
            mem_ready = 1'b1;
`else
            mem_ready = 1'b0;
`endif
            do begin
                nd += int'(instr_done);
                ni += int'(illegal_op);
                n++;
                tick();
            end while (current_state != 4'd0 && n < 20);
            checks++;
            if (n != vecs[k].cyc || nd != vecs[k].done || ni != vecs[k].ill) begin
                failures++;
                $display("FAIL table op=%h cyc/done/ill got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                         vecs[k].op, n, nd, ni, vecs[k].cyc, vecs[k].done, vecs[k].ill);
            end
        end

        // Reset in MEMADR of a lw abandons it.
        Opcode = 6'h23; Funct = 6'h20; mem_ready = 1'b1;
        tick(); tick();
        begin
            ctl_t e;
            e = model(0, 6'h23, 6'h20, 1'b1);
            e.st = 4'd2;
            rst = 1'b0;
            #1;
            check("rst_mid_lw_hold", e);
            tick();
            check("rst_mid_lw_fetch", model(0, 6'h23, 6'h20, 1'b1));
            rst = 1'b1;
        end

`ifdef MEM_WAIT_EN
        // FETCH waits two cycles, sw waits three cycles in MEMWR.
        Opcode = 6'h2B; Funct = 6'h20;
        mem_ready = 1'b0;
        #1 check("wait_fetch0", model(0, 6'h2B, 6'h20, 1'b0));
        tick(); check("wait_fetch1", model(0, 6'h2B, 6'h20, 1'b0));
        mem_ready = 1'b1;
        #1 check("wait_fetch_go", model(0, 6'h2B, 6'h20, 1'b1));
        tick(); check("wait_decode", model(1, 6'h2B, 6'h20, 1'b1));
        tick(); check("wait_memadr", model(2, 6'h2B, 6'h20, 1'b1));
        mem_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick(); check("wait_memwr", model(5, 6'h2B, 6'h20, 1'b0));
        end
        mem_ready = 1'b1;
        #1 check("wait_memwr_done", model(5, 6'h2B, 6'h20, 1'b1));
        tick(); check("wait_back_fetch", model(0, 6'h2B, 6'h20, 1'b1));
        // lw with MEMRD stalled, then reset during the wait.
        Opcode = 6'h23;
        tick(); tick();
        mem_ready = 1'b0;
        tick(); check("wait_memrd", model(3, 6'h23, 6'h20, 1'b0));
        tick(); check("wait_memrd2", model(3, 6'h23, 6'h20, 1'b0));
        rst = 1'b0;
        tick(); check("wait_rst", model(0, 6'h23, 6'h20, 1'b1));
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
`endif

        // Random instruction stream, including random illegal opcodes.
        for (int r = 0; r < 150; r++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom)
                                             : legal_ops[$urandom_range(0, 9)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                             : fns[$urandom_range(0, 6)];
            run_instr("random", op, fn);
        end
        check("final_fetch", model(0, Opcode, Funct, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Parametrised successor of the multicycle MIPS control unit: a Moore control FSM plus ALU decoder that sequences fetch, decode, execute, memory and writeback for the core datapath. It extends the base instruction set with immediate ALU ops (ADDI, ANDI, ORI, SLTI), J, and illegal-opcode trapping. Optional memory wait-state handshake. Sits between the instruction register (Opcode/Funct) and the datapath mux selects and register enables.

## Interface
- STATE_W, 4, width of current_state (min 4)
- ALU_CTL_W, 4, width of ALU_Ctl (min 4; upper bits zero when wider)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- Opcode  in  6  instruction[31:26]
- Funct  in  6  instruction[5:0]
- mem_ready  in  1  memory access complete (used only with MEM_WAIT_EN)
- MemtoReg, RegDst, ALUSrcA  out  1  datapath mux selects
- ALUSrcB, PCSrc  out  2  mux selects (PCSrc 00 ALU, 01 ALUOut, 10 jump target)
- IRWrite, MemWrite, PCWrite, BEQ, BNE, RegWrite  out  1  enables
- ExtOp  out  1  1 = sign-extend immediate, 0 = zero-extend
- ALU_Ctl  out  ALU_CTL_W  ALU operation
- instr_done  out  1  one-cycle pulse in the final state of every instruction
- illegal_op  out  1  one-cycle pulse on unrecognised opcode
- current_state  out  STATE_W  state encoding, for debug/coverage

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, RWB 7, BR 8, IMMEX 9, IMMWB 10, JMP 11, TRAP 12. Unused encodings -> FETCH.
- FETCH: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, PCSrc=00, ALU add. -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target). Opcode 0x23/0x2B -> MEMADR; 0x00 -> REX; 0x04/0x05 -> BR; 0x08/0x0C/0x0D/0x0A -> IMMEX; 0x02 -> JMP; else -> TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add, ExtOp=1. lw -> MEMRD, sw -> MEMWR.
- MEMRD -> MEMWB (RegWrite=1, MemtoReg=1, RegDst=0, instr_done). MEMWR: MemWrite=1, instr_done.
- REX: ALUSrcA=1, ALUSrcB=00, ALU from Funct. RWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done.
- BR: ALUSrcA=1, ALUSrcB=00, subtract, PCSrc=01, BEQ=1 for 0x04 / BNE=1 for 0x05, instr_done.
- IMMEX: ALUSrcA=1, ALUSrcB=10; ADDI add/ExtOp=1, SLTI slt/ExtOp=1, ANDI and/ExtOp=0, ORI or/ExtOp=0. IMMWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done; ExtOp/ALU_Ctl held per opcode.
- JMP: PCWrite=1, PCSrc=10, instr_done. TRAP: illegal_op=1, no enables; -> FETCH.
- ALU_Ctl codes: and 0000, or 0001, add 0010, sub 0110, slt 0111, nor 1100. Funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt, other -> add.
- Opcode/Funct sampled combinationally every cycle; the IR holds them stable after FETCH.
- All outputs Moore (decoded from state plus Opcode/Funct); every enable not listed for a state is 0.

## Timing
- Reset: state=FETCH on first edge with rst=0; outputs while in reset are the FETCH values (IRWrite=1, PCWrite=1, ALUSrcB=01, ALU_Ctl=0010, others 0). Reset mid-instruction abandons it; no instr_done.
- Cycles (no waits): lw 5, sw 4, R-type 4, immediate 4, beq/bne 3, j 3, illegal 3 (TRAP pulse in cycle 3).
- instr_done and illegal_op mutually exclusive, each exactly one cycle per instruction.

## Configuration
- MEM_WAIT_EN defined: FETCH, MEMRD, MEMWR hold while mem_ready=0; IRWrite and PCWrite in FETCH asserted only in the cycle mem_ready=1; MemWrite held every MEMWR cycle; instr_done in MEMWR only when mem_ready=1. Reset overrides a pending wait.
- Undefined: mem_ready ignored; each of those states lasts exactly one cycle.

## Structure
- Package mips_mc_pkg: state enum, opcode and funct constants, ALU_Ctl codes, internal ALUOp encoding (add, sub, funct, and, or, slt).
- One sub-module mips_alu_dec: combinational ALUOp + Funct -> ALU_Ctl.

## Test plan
- Reset then lw (0x23): states 0,1,2,3,4; RegWrite=MemtoReg=1 in cycle 5 only; instr_done once.
- R-type Funct 0x22: ALU_Ctl=0110 in REX; RWB RegDst=1, RegWrite=1; Funct 0x3F yields 0010.
- bne (0x05): state 8 in cycle 3, BNE=1, BEQ=0, PCSrc=01, ALU_Ctl=0110; back to FETCH.
- ORI (0x0D): ExtOp=0, ALU_Ctl=0001 in IMMEX and IMMWB; ADDI (0x08): ExtOp=1, 0010.
- Opcode 0x3F: TRAP, illegal_op one cycle, no enables, no instr_done; rst=0 mid-lw returns to FETCH next edge.
- MEM_WAIT_EN, mem_ready low 3 cycles in MEMWR: MemWrite high 4 cycles, instr_done only on last.
